regfile_sb: RTL

Parametrised multi-port integer register file with write-through bypass and an integrated pending-write scoreboard. It is the next-generation architectural register file for the pipelined CPU. Decode reads operands and busy status from it, issue marks destination registers pending, and writeback ports clear them. A debug read port and a write-conflict counter replace whole-array export for simulator monitoring.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, write-port select payload and collision-resolve helper for the register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned MAX_WR   = 16;
   localparam int unsigned IDX_W    = 4;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
   } wr_sel_t;

   // Highest-indexed matching write port wins.
   function automatic wr_sel_t hi_match(input logic [MAX_WR-1:0] match);
      wr_sel_t sel;
      sel = '0;
      for (int unsigned i = 0; i < MAX_WR; i++) begin
         if (match[i]) begin
            sel.hit = 1'b1;
            sel.idx = IDX_W'(i);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue sets, writeback clears.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              iss_en,
   input  logic [AW-1:0]     iss_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [NRD-1:0]  rd_hit;

   // Clears applied first so a same-cycle issue re-marks the register.
   always_comb begin
      busy_nxt = busy;
      for (int unsigned w = 0; w < NWR; w++) begin
         if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (iss_en) busy_nxt[iss_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   always_comb begin
      rd_hit  = '0;
      rd_busy = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])) rd_hit[i] = 1'b1;
         end
         rd_busy[i] = busy[rd_addr[i*AW +: AW]] & ~rd_hit[i];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass, pending-write scoreboard and collision counter.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data,
   output logic [CNT_W-1:0]    conflict_cnt
);

   logic [XLEN-1:0]   rf [NREG];
   logic [MAX_WR-1:0] rd_match [NRD];
   wr_sel_t           rd_sel [NRD];
   logic              collide;

   // Later ports overwrite earlier ones, so the highest index wins a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) rf[r] <= '0;
      end else begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
               rf[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         rd_match[i] = '0;
         for (int unsigned w = 0; w < NWR; w++) begin
            rd_match[i][w] = wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW]);
         end
         rd_sel[i] = hi_match(rd_match[i]);
         if (rd_addr[i*AW +: AW] != '0) begin
            if (rd_sel[i].hit) rd_data[i*XLEN +: XLEN] = wr_data[rd_sel[i].idx*XLEN +: XLEN];
            else               rd_data[i*XLEN +: XLEN] = rf[rd_addr[i*AW +: AW]];
         end
      end
   end

   assign dbg_data = rf[dbg_addr];

   // Discarded writes to x0 are not counted as collisions.
   always_comb begin
      collide = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
         for (int unsigned j = i + 1; j < NWR; j++) begin
            if (wr_en[i] && wr_en[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
                && (wr_addr[i*AW +: AW] != '0))
               collide = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                                 conflict_cnt <= '0;
      else if (collide && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_W'(1);
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR),
      .AW   (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

endmodule
